// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS commands into 32-bit words and streams them to instruction memory.
// Optional ENC_REL_BRANCH_EN: BEQ/BNE cmd_imm is an absolute word address converted to a PC-relative offset.
module mips_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              iw_valid,
  input  logic              iw_ready,
  output logic [ADDR_W-1:0] iw_addr,
  output logic [31:0]       iw_data,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  count_r;
  logic              last_taken_r;
  logic              iw_last_r;

  logic              hs_s;
  logic              accept_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [CNT_W-1:0]  inflight_s;
  logic [15:0]       br_imm_s;
  logic [32:0]       enc_s;

  // Returns {illegal, word}; unused fields of each format are never copied.
  function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [15:0] br_imm,
                                         input logic [25:0] target);
    case (op)
      4'd0:    encode = {1'b0, 6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd1:    encode = {1'b0, 6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd2:    encode = {1'b0, 6'h00, rs, rt, rd, 5'h00, 6'h24};
      4'd3:    encode = {1'b0, 6'h00, rs, rt, rd, 5'h00, 6'h25};
      4'd4:    encode = {1'b0, 6'h00, rs, rt, rd, 5'h00, 6'h2A};
      4'd5:    encode = {1'b0, 6'h08, rs, rt, imm};
      4'd6:    encode = {1'b0, 6'h0D, rs, rt, imm};
      4'd7:    encode = {1'b0, 6'h23, rs, rt, imm};
      4'd8:    encode = {1'b0, 6'h2B, rs, rt, imm};
      4'd9:    encode = {1'b0, 6'h04, rs, rt, br_imm};
      4'd10:   encode = {1'b0, 6'h05, rs, rt, br_imm};
      4'd11:   encode = {1'b0, 6'h02, target};
      4'd12:   encode = {1'b0, 6'h03, target};
      default: encode = {1'b1, 32'h0000_0000};
    endcase
  endfunction

  assign hs_s = iw_valid && iw_ready;

  // A pending word that completes this cycle takes pc, so the new word lands one past it.
  always_comb begin
    waddr_s    = pc_r + (iw_valid ? ADDR_W'(1) : ADDR_W'(0));
    inflight_s = count_r + (iw_valid ? CNT_W'(1) : CNT_W'(0));
`ifdef ENC_REL_BRANCH_EN
    br_imm_s   = cmd_imm - 16'(waddr_s) - 16'd1;
`else
    br_imm_s   = cmd_imm;
`endif
    enc_s      = encode(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, br_imm_s, cmd_target);
  end

  // Ready only with room in the output register, region space for this word, and no last yet.
  always_comb begin
    if (state_r == RUN) begin
      cmd_ready = (!iw_valid || iw_ready) && (inflight_s < CNT_W'(DEPTH)) && !last_taken_r;
    end else begin
      cmd_ready = 1'b0;
    end
  end

  assign accept_s = cmd_valid && cmd_ready;

  // Control FSM, program counter and registered memory-write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= '0;
      count_r      <= '0;
      last_taken_r <= 1'b0;
      iw_last_r    <= 1'b0;
      iw_valid     <= 1'b0;
      iw_addr      <= '0;
      iw_data      <= 32'h0000_0000;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          if (start) begin
            state_r      <= RUN;
            pc_r         <= base_addr;
            count_r      <= '0;
            last_taken_r <= 1'b0;
            iw_last_r    <= 1'b0;
            iw_valid     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end
        RUN: begin
          if (hs_s) begin
            pc_r    <= pc_r + ADDR_W'(1);
            count_r <= count_r + CNT_W'(1);
            if (iw_last_r) begin
              state_r <= FIN;
              done    <= 1'b1;
            end else if (count_r + CNT_W'(1) == CNT_W'(DEPTH)) begin
              state_r <= FIN;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
          if (accept_s) begin
            iw_valid     <= 1'b1;
            iw_data      <= enc_s[31:0];
            iw_addr      <= waddr_s;
            iw_last_r    <= cmd_last;
            last_taken_r <= cmd_last;
            if (enc_s[32]) begin
              err <= 1'b1;
            end
          end else if (hs_s) begin
            iw_valid <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: expected writes queued on accept, checked on memory handshake.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, s_start;
  logic [7:0]  base_addr;
  logic        cmd_valid, s_cmd_valid;
  logic        cmd_ready, s_cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        cmd_last;
  logic        iw_valid, s_iw_valid;
  logic        iw_ready;
  logic        s_iw_ready;
  logic [7:0]  iw_addr, s_iw_addr;
  logic [31:0] iw_data, s_iw_data;
  logic        done, s_done;
  logic        err, s_err;

  int n_tests = 0;
  int n_fail  = 0;
  int s_writes = 0;
  logic [7:0]  exp_pc;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last), .iw_valid(iw_valid),
    .iw_ready(iw_ready), .iw_addr(iw_addr), .iw_data(iw_data),
    .done(done), .err(err));

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base_addr(base_addr),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last), .iw_valid(s_iw_valid),
    .iw_ready(s_iw_ready), .iw_addr(s_iw_addr), .iw_data(s_iw_data),
    .done(s_done), .err(s_err));

  // Reference encoding of one command written at address addr.
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm,
                                      input logic [25:0] tgt, input logic [7:0] addr);
    logic [5:0]  f;
    logic [15:0] off;
    off = imm;
`ifdef ENC_REL_BRANCH_EN
    off = imm - {8'h00, addr} - 16'd1;
`endif
    case (op)
      4'd0: f = 6'h20;
      4'd1: f = 6'h22;
      4'd2: f = 6'h24;
      4'd3: f = 6'h25;
      default: f = 6'h2A;
    endcase
    if (op <= 4'd4)       enc = {6'h00, rs, rt, rd, 5'h00, f};
    else if (op == 4'd5)  enc = {6'h08, rs, rt, imm};
    else if (op == 4'd6)  enc = {6'h0D, rs, rt, imm};
    else if (op == 4'd7)  enc = {6'h23, rs, rt, imm};
    else if (op == 4'd8)  enc = {6'h2B, rs, rt, imm};
    else if (op == 4'd9)  enc = {6'h04, rs, rt, off};
    else if (op == 4'd10) enc = {6'h05, rs, rt, off};
    else if (op == 4'd11) enc = {6'h02, tgt};
    else if (op == 4'd12) enc = {6'h03, tgt};
    else                  enc = 32'h0000_0000;
  endfunction

  // Scoreboard: every completed memory write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && iw_valid && iw_ready) begin
      logic [39:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got addr=%0h data=%08h, required no write", iw_addr, iw_data);
      end else begin
        e = exp_q.pop_front();
        if ({iw_addr, iw_data} !== e) begin
          n_fail++;
          $display("FAIL scoreboard_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   iw_addr, iw_data, e[39:32], e[31:0]);
        end
      end
    end
  end

  // Counts writes of the small-region instance.
  always @(negedge clk) begin
    if (rst_n && s_iw_valid && s_iw_ready) s_writes++;
  end

  task automatic set_cmd(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = last;
  endtask

  task automatic do_start(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    exp_pc = b;
  endtask

  task automatic send_raw(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic last, input logic [31:0] word);
    bit acc = 1'b0;
    set_cmd(op, rs, rt, rd, imm, tgt, last);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({exp_pc, word});
        exp_pc = exp_pc + 8'd1;
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 50 cycles, required 1 (op=%0d)", op);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last);
    send_raw(op, rs, rt, rd, imm, tgt, last, enc(op, rs, rt, rd, imm, tgt, exp_pc));
  endtask

  task automatic wait_done(input logic exp_err);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got done=0 for 50 cycles, required 1");
    end
    n_tests++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL err_at_done: got %b, required %b", err, exp_err);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL words_missing: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_ready, iw_valid, iw_addr, iw_data, done, err} !== 44'h0) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b v=%b a=%0h d=%08h done=%b err=%b, required all 0",
                 cmd_ready, iw_valid, iw_addr, iw_data, done, err);
      end
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic test_single_add;
    do_start(8'h00);
    send_raw(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    wait_done(1'b0);
    cmd_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_done: got %b, required 0", cmd_ready);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words[3];
    words[0] = 32'h2008_0005; words[1] = 32'h8FA9_0004; words[2] = 32'h0800_0010;
    do_start(8'h00);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       set_cmd(4'd5,  5'd0,  5'd8, 5'd0, 16'd5, 26'h0, 1'b0);
        1:       set_cmd(4'd7,  5'd29, 5'd9, 5'd0, 16'd4, 26'h0, 1'b0);
        default: set_cmd(4'd11, 5'd0,  5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
      endcase
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: got %b at cmd %0d, required 1", cmd_ready, k);
      end
      exp_q.push_back({exp_pc, words[k]});
      exp_pc = exp_pc + 8'd1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_done(1'b0);
  endtask

  task automatic test_backpressure;
    do_start(8'h10);
    iw_ready = 1'b0;
    send(4'd5, 5'd2, 5'd1, 5'd0, 16'h1234, 26'h0, 1'b0);
    set_cmd(4'd6, 5'd3, 5'd4, 5'd0, 16'hBEEF, 26'h0, 1'b1);
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({iw_valid, iw_addr, iw_data, cmd_ready} !== {1'b1, 8'h10, 32'h2041_1234, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b a=%0h d=%08h rdy=%b, required v=1 a=10 d=20411234 rdy=0",
                 iw_valid, iw_addr, iw_data, cmd_ready);
      end
      @(posedge clk); #1;
    end
    iw_ready = 1'b1;
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'hBEEF, 26'h0, 1'b1);
    wait_done(1'b0);
  endtask

  task automatic test_illegal;
    do_start(8'h40);
    send_raw(4'd14, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0000_0000);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err: got %b, required 1", err);
    end
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1);
    wait_done(1'b1);
  endtask

  task automatic test_depth;
    int accepted = 0;
    s_writes = 0;
    @(posedge clk); #1 s_start = 1'b1; base_addr = 8'hFE;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit acc = 1'b0;
      set_cmd(4'd3, 5'(k), 5'd1, 5'd2, 16'h0, 26'h0, 1'b0);
      s_cmd_valid = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
        @(negedge clk);
        acc = s_cmd_ready;
        @(posedge clk); #1;
      end
      if (acc) accepted++;
    end
    s_cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({accepted, s_writes} !== {32'd4, 32'd4}) begin
      n_fail++;
      $display("FAIL depth_count: got accepted=%0d writes=%0d, required 4 and 4", accepted, s_writes);
    end
    n_tests++;
    if ({s_done, s_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL depth_flags: got done=%b err=%b, required 1 1", s_done, s_err);
    end
  endtask

  task automatic test_rel_branch;
    logic [31:0] w;
`ifdef ENC_REL_BRANCH_EN
    w = 32'h1022_FFFD;
`else
    w = 32'h1022_0001;
`endif
    do_start(8'h00);
    repeat (3) send_raw(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0000_0020);
    send_raw(4'd9, 5'd1, 5'd2, 5'd0, 16'd1, 26'h0, 1'b1, w);
    wait_done(1'b0);
  endtask

  task automatic test_reset_mid;
    do_start(8'h20);
    iw_ready = 1'b0;
    set_cmd(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n_tests++;
    if (iw_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pending: got iw_valid=%b, required 1", iw_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    n_tests++;
    if ({iw_valid, iw_addr, iw_data, done, err, cmd_ready} !== 44'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b a=%0h d=%08h done=%b err=%b rdy=%b, required all 0",
               iw_valid, iw_addr, iw_data, done, err, cmd_ready);
    end
    iw_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_start = 1'b0; base_addr = 8'h00;
    cmd_valid = 1'b0; s_cmd_valid = 1'b0; iw_ready = 1'b1; s_iw_ready = 1'b1;
    exp_pc = 8'h00;
    set_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
    test_reset;
    test_single_add;
    test_back_to_back;
    test_backpressure;
    test_illegal;
    test_depth;
    test_rel_branch;
    test_reset_mid;
    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the opcode-to-control decode path: takes symbolic instruction commands and encodes 32-bit MIPS words for the supported subset (ADD, SUB, AND, OR, SLT, ADDI, ORI, LW, SW, BEQ, BNE, J, JAL).
- Streams each encoded word into instruction memory at consecutive word addresses.
- Used by the bench and the boot loader to build programs for the single-cycle core.
- Valid/ready command input; registered memory-write output with backpressure.

Parameters:
- ADDR_W, 8, width of the word address into instruction memory.
- DEPTH, 256, number of words the program region holds (must be ≤ 2^ADDR_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset. One clock only.
- start  in  1  pulse; loads base address and begins a program.
- base_addr  in  ADDR_W  first word address, sampled on start.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  encoder accepts command this cycle.
- cmd_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 ORI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J, 12 JAL; 13-15 illegal.
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields.
- cmd_imm  in  16  immediate / branch offset.
- cmd_target  in  26  jump target.
- cmd_last  in  1  final command of the program.
- iw_valid  out  1  write request to instruction memory.
- iw_ready  in  1  memory accepts write.
- iw_addr  out  ADDR_W  word address.
- iw_data  out  32  encoded instruction.
- done  out  1  program complete (level).
- err  out  1  sticky: illegal op or region full.

Behaviour:
- Reset values: cmd_ready=0, iw_valid=0, iw_addr=0, iw_data=0, done=0, err=0, FSM=IDLE, word count=0.
- FSM IDLE:
  - start → RUN; pc←base_addr, count←0, done←0, err←0.
- FSM RUN:
  - cmd_ready = (!iw_valid || iw_ready) && count<DEPTH && !last_taken.
  - Accept (cmd_valid&&cmd_ready): next cycle iw_valid=1 with the encoded word (1-cycle latency), iw_addr=pc.
- Memory handshake:
  - iw_valid and iw_data/iw_addr held stable until iw_ready.
  - On iw_valid&&iw_ready: pc←pc+1 (wraps modulo 2^ADDR_W), count←count+1.
  - Back-to-back accept is allowed in the same cycle as a memory handshake: full throughput, 1 word/cycle.
- RUN → DONE: when the word tagged cmd_last completes its memory handshake, or when count reaches DEPTH. Reaching DEPTH with no last also sets err.
- DONE:
  - done=1, cmd_ready=0.
  - start → RUN (restart); start is ignored in RUN.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'h0, funct}; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: {opc, rs, rt, imm}; opc ADDI 0x08, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J-type: {opc, target}; J 0x02, JAL 0x03.
  - Unused fields are ignored, never copied.
- Illegal cmd_op:
  - Accepted normally; emits 32'h00000000 (NOP) and sets err.
  - Program continues.
- Reset mid-operation: in-flight word dropped (iw_valid=0 next cycle), all state to reset values.
- cmd_valid while IDLE/DONE: not accepted; no state change.

Optional Feature:
- Macro: ENC_REL_BRANCH_EN.
- Defined:
  - For BEQ/BNE, cmd_imm is an absolute word address.
  - Encoder writes imm = cmd_imm − (addr_of_this_word + 1), truncated to 16 bits.
  - addr_of_this_word is the address the word will be written to, accounting for a word still pending in the output register.
- Undefined: cmd_imm is copied verbatim as the offset.

Test Plan:
- start, base 0; ADD rd=3 rs=1 rt=2 with cmd_last, iw_ready=1 → iw_data=0x00221820 at addr 0 one cycle after accept; done=1 next cycle; err=0.
- ADDI rt=8 rs=0 imm=5; LW rt=9 rs=29 imm=4; J target=0x10, back-to-back, iw_ready=1:
  - → 0x20080005 @0, 0x8FA90004 @1, 0x08000010 @2.
  - cmd_ready stays high throughout.
- Hold iw_ready=0 for 3 cycles with a word pending → iw_data/addr stable, cmd_ready=0, pc unchanged; release → resumes, no word lost or duplicated.
- cmd_op=14 → word 0x00000000 written, err=1, next command still encoded and written.
- DEPTH=4, five commands without cmd_last → four words written, state DONE, err=1, fifth command not accepted.
- With ENC_REL_BRANCH_EN:
  - Three NOPs (ADD rd=0 rs=0 rt=0), then BEQ rs=1 rt=2 imm=1 at addr 3 → 0x1022FFFD.
  - Without the macro, the same command gives 0x10220001.
